bomber_info_data_regs: RTL and testbench

- Upstream feeder of the per-player info text overlay: holds the status word that the overlay reads through its 1-bit player address.
- Accepts raw binary player status (x/y position, lives, bombs) from game logic via a write handshake.
- Converts positions to two decimal digits in a small multi-cycle FSM, then stages the result.
- Commits staged data to display registers; the overlay sees a 14-bit packed word selected combinationally by player address.

---
 rtl/bomber_info_data_regs_if.sv | 30 +++
 rtl/bomber_info_data_regs.sv | 176 +++++++++++++++++
 tb/tb_bomber_info_data_regs.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bomber_info_data_regs_if.sv
// Write/read bus between game logic, the info overlay and bomber_info_data_regs.
//   master: game logic + overlay (drives write request/data and read address)
//   slave : bomber_info_data_regs (returns ready, clamp pulse and read data)
//   i_wr/i_wr_player/i_pos_x/i_pos_y/i_lives/i_bombs : write request and payload
//   o_ready : write can be accepted, o_clamp : accepted write was clamped
//   i_axi_addr/o_axi_data : overlay player select and 14-bit packed word
interface bomber_info_data_regs_if #(
    parameter int unsigned POS_WIDTH = 5
);
    logic                 i_wr;
    logic                 i_wr_player;
    logic [POS_WIDTH-1:0] i_pos_x;
    logic [POS_WIDTH-1:0] i_pos_y;
    logic [1:0]           i_lives;
    logic [1:0]           i_bombs;
    logic                 o_ready;
    logic                 o_clamp;
    logic                 i_axi_addr;
    logic [13:0]          o_axi_data;

    modport master (
        output i_wr, i_wr_player, i_pos_x, i_pos_y, i_lives, i_bombs, i_axi_addr,
        input  o_ready, o_clamp, o_axi_data
    );

    modport slave (
        input  i_wr, i_wr_player, i_pos_x, i_pos_y, i_lives, i_bombs, i_axi_addr,
        output o_ready, o_clamp, o_axi_data
    );
endinterface

// File: rtl/bomber_info_data_regs.sv
// Per-player status registers feeding the info text overlay.
// Accepts binary player status through a write handshake, clamps positions,
// converts them to two decimal digits over a small FSM and commits the packed
// word to a display register read combinationally by player address.
// Ports:
//   i_pclk  : clock, rising edge
//   i_rst   : synchronous active-high reset
//   i_vsync : frame sync, used for frame-boundary commit
//   bus     : slave side of bomber_info_data_regs_if (write + read path)
// Optional feature macro BOMBER_INFO_FRAME_SYNC_EN: when defined, staged words
// are committed to the display registers only on a vsync rising edge.
module bomber_info_data_regs #(
    parameter int unsigned POS_WIDTH   = 5,
    parameter int unsigned POS_MAX     = 19,
    parameter int unsigned RESET_LIVES = 3,
    parameter int unsigned RESET_BOMBS = 1
) (
    input  logic              i_pclk,
    input  logic              i_rst,
    input  logic              i_vsync,
    bomber_info_data_regs_if.slave bus
);

    localparam int unsigned          WORD_W     = 14;
    localparam logic [POS_WIDTH-1:0] POS_MAX_W  = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0] TEN_W      = POS_WIDTH'(10);
    localparam logic [WORD_W-1:0]    RESET_WORD = {2'(RESET_BOMBS), 2'(RESET_LIVES), 10'b0};

    typedef struct packed {
        logic [1:0] bombs;
        logic [1:0] lives;
        logic [3:0] y_ones;
        logic       y_tens;
        logic [3:0] x_ones;
        logic       x_tens;
    } info_word_t;

    typedef enum logic [1:0] {S_IDLE, S_CONV_X, S_CONV_Y, S_STAGE} state_t;

    state_t               state_q, state_d;
    logic                 ready_q;
    logic                 clamp_q;
    logic                 lat_player;
    logic [POS_WIDTH-1:0] lat_x, lat_y;
    logic [1:0]           lat_lives, lat_bombs;
    logic                 x_tens_q, y_tens_q;
    logic [3:0]           x_ones_q, y_ones_q;
    logic [WORD_W-1:0]    disp_q [2];

    logic                 accept_c;
    logic                 x_over_c, y_over_c;
    logic [POS_WIDTH-1:0] conv_src_c;
    logic                 conv_tens_c;
    logic [3:0]           conv_ones_c;
    info_word_t           stage_word_c;

`ifdef BOMBER_INFO_FRAME_SYNC_EN
    logic [WORD_W-1:0]    stage_q [2];
    logic [1:0]           pending_q;
    logic                 vsync_q;
    logic                 vsync_rise_c;

    assign vsync_rise_c = i_vsync && !vsync_q;
`else
    logic                 unused_vsync;

    assign unused_vsync = i_vsync;
`endif

    assign accept_c = bus.i_wr && ready_q;
    assign x_over_c = bus.i_pos_x > POS_MAX_W;
    assign y_over_c = bus.i_pos_y > POS_MAX_W;

    // One shared binary-to-decimal converter, x in CONV_X and y in CONV_Y.
    assign conv_src_c  = (state_q == S_CONV_X) ? lat_x : lat_y;
    assign conv_tens_c = conv_src_c >= TEN_W;
    assign conv_ones_c = 4'(conv_tens_c ? (conv_src_c - TEN_W) : conv_src_c);

    always_comb begin
        stage_word_c.bombs  = lat_bombs;
        stage_word_c.lives  = lat_lives;
        stage_word_c.y_ones = y_ones_q;
        stage_word_c.y_tens = y_tens_q;
        stage_word_c.x_ones = x_ones_q;
        stage_word_c.x_tens = x_tens_q;
    end

    // State register.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept_c) state_d = S_CONV_X;
            S_CONV_X: state_d = S_CONV_Y;
            S_CONV_Y: state_d = S_STAGE;
            S_STAGE:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: latch, convert, stage and commit.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            ready_q    <= 1'b1;
            clamp_q    <= 1'b0;
            lat_player <= 1'b0;
            lat_x      <= '0;
            lat_y      <= '0;
            lat_lives  <= '0;
            lat_bombs  <= '0;
            x_tens_q   <= 1'b0;
            x_ones_q   <= '0;
            y_tens_q   <= 1'b0;
            y_ones_q   <= '0;
            disp_q[0]  <= RESET_WORD;
            disp_q[1]  <= RESET_WORD;
`ifdef BOMBER_INFO_FRAME_SYNC_EN
            stage_q[0] <= '0;
            stage_q[1] <= '0;
            pending_q  <= '0;
            vsync_q    <= 1'b0;
`endif
        end else begin
            ready_q <= (state_d == S_IDLE);
            clamp_q <= 1'b0;
            if (accept_c) begin
                lat_player <= bus.i_wr_player;
                lat_x      <= x_over_c ? POS_MAX_W : bus.i_pos_x;
                lat_y      <= y_over_c ? POS_MAX_W : bus.i_pos_y;
                lat_lives  <= bus.i_lives;
                lat_bombs  <= bus.i_bombs;
                clamp_q    <= x_over_c || y_over_c;
            end
            if (state_q == S_CONV_X) begin
                x_tens_q <= conv_tens_c;
                x_ones_q <= conv_ones_c;
            end
            if (state_q == S_CONV_Y) begin
                y_tens_q <= conv_tens_c;
                y_ones_q <= conv_ones_c;
            end
`ifdef BOMBER_INFO_FRAME_SYNC_EN
            vsync_q <= i_vsync;
            for (int p = 0; p < 2; p++) begin
                if (vsync_rise_c && pending_q[p]) begin
                    disp_q[p]    <= stage_q[p];
                    pending_q[p] <= 1'b0;
                end
            end
            // Placed after the commit loop so a word staged on the vsync edge
            // keeps its pending flag and waits for the next frame.
            if (state_q == S_STAGE) begin
                stage_q[lat_player]   <= stage_word_c;
                pending_q[lat_player] <= 1'b1;
            end
`else
            if (state_q == S_STAGE) begin
                disp_q[lat_player] <= stage_word_c;
            end
`endif
        end
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_clamp    = clamp_q;
    assign bus.o_axi_data = bus.i_axi_addr ? disp_q[1] : disp_q[0];

endmodule

// File: tb/tb_bomber_info_data_regs.sv
// Scoreboard bench for bomber_info_data_regs: stimulus pushes the expected
// outputs for the current cycle, a negedge monitor pops and compares them.
module tb_bomber_info_data_regs;

    logic clk;
    logic rst;
    logic vsync;

    bomber_info_data_regs_if #(.POS_WIDTH(5)) bus ();

    bomber_info_data_regs #(
        .POS_WIDTH  (5),
        .POS_MAX    (19),
        .RESET_LIVES(3),
        .RESET_BOMBS(1)
    ) dut (
        .i_pclk (clk),
        .i_rst  (rst),
        .i_vsync(vsync),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel: 0 = o_axi_data, 1 = o_ready, 2 = o_clamp pulse
    typedef struct {
        int          sel;
        logic [13:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check_val(input string name, input logic [13:0] act, input logic [13:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_val(input int sel, input logic [13:0] v, input string name);
        exp_t e;
        e.sel  = sel;
        e.val  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: compares everything queued for this cycle; an unqueued clamp pulse fails.
    exp_t mon_e;
    logic mon_clamp_exp;
    always @(negedge clk) begin
        mon_clamp_exp = 1'b0;
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e.sel)
                0:       check_val(mon_e.name, bus.o_axi_data, mon_e.val);
                1:       check_val(mon_e.name, 14'(bus.o_ready), mon_e.val);
                default: mon_clamp_exp = 1'b1;
            endcase
        end
        if (mon_clamp_exp || (bus.o_clamp === 1'b1))
            check_val("clamp_pulse", 14'(bus.o_clamp), 14'(mon_clamp_exp));
    end

    // Independent model of the packed word: clamp to 19, then split into digits.
    function automatic logic [13:0] model_word(input int x, input int y, input int l, input int b);
        int cx, cy;
        cx = (x > 19) ? 19 : x;
        cy = (y > 19) ? 19 : y;
        return {2'(b), 2'(l), 4'(cy % 10), 1'(cy / 10), 4'(cx % 10), 1'(cx / 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ends in cycle T+4 with o_ready expected high again.
    task automatic do_write(input logic p, input int x, input int y, input int l, input int b,
                            input bit clamp_exp, input bit vs_at_stage);
        tick();
        bus.i_wr        = 1'b1;
        bus.i_wr_player = p;
        bus.i_pos_x     = 5'(x);
        bus.i_pos_y     = 5'(y);
        bus.i_lives     = 2'(l);
        bus.i_bombs     = 2'(b);
        expect_val(1, 14'd1, "ready_before_accept");
        tick();
        bus.i_wr = 1'b0;
        expect_val(1, 14'd0, "ready_t1");
        if (clamp_exp) expect_val(2, 14'd1, "clamp");
        tick();
        expect_val(1, 14'd0, "ready_t2");
        tick();
        if (vs_at_stage) vsync = 1'b1;
        expect_val(1, 14'd0, "ready_t3");
        tick();
        vsync = 1'b0;
        expect_val(1, 14'd1, "ready_t4");
    endtask

    // Reads one address in the current cycle, then advances a cycle.
    task automatic check_read(input logic a, input logic [13:0] v, input string name);
        bus.i_axi_addr = a;
        expect_val(0, v, name);
        tick();
    endtask

    // One-cycle vsync high; returns in the cycle after the rising edge is sampled.
    task automatic vsync_pulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        vsync           = 1'b0;
        bus.i_wr        = 1'b0;
        bus.i_wr_player = 1'b0;
        bus.i_pos_x     = '0;
        bus.i_pos_y     = '0;
        bus.i_lives     = '0;
        bus.i_bombs     = '0;
        bus.i_axi_addr  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        expect_val(1, 14'd1, "reset_ready");
        check_read(1'b0, 14'h1C00, "reset_addr0");
        check_read(1'b1, 14'h1C00, "reset_addr1");

        // Player 0: x=13 y=7 lives=2 bombs=3.
        do_write(1'b0, 13, 7, 2, 3, 1'b0, 1'b0);
`ifdef BOMBER_INFO_FRAME_SYNC_EN
        check_read(1'b0, 14'h1C00, "p0_held_midframe");
        vsync_pulse();
`endif
        check_read(1'b0, 14'h39C7, "p0_write");
        check_read(1'b1, 14'h1C00, "p1_untouched");

        // Player 1: both positions clamped to 19.
        do_write(1'b1, 25, 31, 0, 0, 1'b1, 1'b0);
`ifdef BOMBER_INFO_FRAME_SYNC_EN
        check_read(1'b1, 14'h1C00, "p1_held_midframe");
        vsync_pulse();
`endif
        check_read(1'b1, 14'h0273, "p1_clamped");
        check_read(1'b0, 14'h39C7, "p0_kept");

        // i_wr held high with new data every cycle: cycles 0,4,8,12 are accepted.
        tick();
        for (int i = 0; i <= 12; i++) begin
            bus.i_wr        = 1'b1;
            bus.i_wr_player = 1'b1;
            bus.i_pos_x     = 5'(i + 5);
            bus.i_pos_y     = 5'(12 - i);
            bus.i_lives     = 2'(i % 4);
            bus.i_bombs     = 2'((i / 4) % 4);
            expect_val(1, 14'((i % 4) == 0), "stream_ready");
            tick();
        end
        bus.i_wr = 1'b0;
        expect_val(1, 14'd0, "stream_ready_t1");
        tick();
        tick();
        tick();
        expect_val(1, 14'd1, "stream_ready_t4");
`ifdef BOMBER_INFO_FRAME_SYNC_EN
        vsync_pulse();
`endif
        check_read(1'b1, model_word(17, 0, 0, 3), "stream_last_wins");
        check_read(1'b0, 14'h39C7, "stream_p0_kept");

`ifdef BOMBER_INFO_FRAME_SYNC_EN
        // STAGE on the vsync edge: deferred to the following frame.
        do_write(1'b0, 5, 18, 1, 0, 1'b0, 1'b1);
        check_read(1'b0, 14'h39C7, "coincide_deferred");
        vsync_pulse();
        check_read(1'b0, model_word(5, 18, 1, 0), "coincide_next_frame");
`endif

        // Reset during CONV_Y: nothing of that write survives.
        tick();
        bus.i_wr        = 1'b1;
        bus.i_wr_player = 1'b0;
        bus.i_pos_x     = 5'd2;
        bus.i_pos_y     = 5'd3;
        bus.i_lives     = 2'd1;
        bus.i_bombs     = 2'd1;
        tick();
        bus.i_wr = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_val(1, 14'd1, "rst_mid_ready");
        check_read(1'b0, 14'h1C00, "rst_mid_addr0");
        check_read(1'b1, 14'h1C00, "rst_mid_addr1");
        vsync_pulse();
        check_read(1'b0, 14'h1C00, "rst_mid_no_commit");
        tick();

        @(negedge clk);
        #1;
        check_val("scoreboard_drained", 14'(exp_q.size()), 14'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
